// File: rtl/btn_inst_frontend_pkg.sv
// Shared constants for the operator front end and the sequencer input path.
// Holds the instruction/tag defaults and the tag formula helper.
package btn_inst_frontend_pkg;

  localparam int SEQ_IN_WIDTH  = 8;
  localparam int SEQ_TAG_WIDTH = 2;

  // Tag forced into the instruction MSBs for button k >= 1.
  function automatic logic [31:0] btn_tag(
    input logic [31:0] k,
    input int          tw
  );
    return (32'd1 << tw) - k;
  endfunction

endpackage

// File: rtl/btn_inst_frontend_debounce.sv
// One button channel: tick-sampled shift register, stable level,
// optional auto-repeat counter and a registered one-cycle press pulse.
module btn_debounce
  import btn_inst_frontend_pkg::*;
#(
  parameter int DEB_DEPTH    = 3,
  parameter int REPEAT_TICKS = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_btn,
  output logic o_press
);

  localparam int   RW     = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;
  localparam logic REP_EN = (REPEAT_TICKS > 0);

  logic [DEB_DEPTH-1:0] r_sh;
  logic                 r_level;
  logic                 r_press;
  logic [RW-1:0]        r_rep;

  logic [DEB_DEPTH-1:0] w_sh_next;
  logic                 w_all1;
  logic                 w_all0;
  logic                 w_lvl_next;
  logic                 w_rise;
  logic                 w_rep_hit;

  assign w_sh_next  = {r_sh[DEB_DEPTH-2:0], i_btn};
  assign w_all1     = &w_sh_next;
  assign w_all0     = ~|w_sh_next;
  assign w_lvl_next = w_all1 | (r_level & ~w_all0);
  assign w_rise     = i_tick & ~r_level & w_all1;

  // Repeat fires on the tick that brings the held count to REPEAT_TICKS.
  assign w_rep_hit = REP_EN & i_tick & r_level & w_lvl_next
                   & ((r_rep + 1'b1) == RW'(REPEAT_TICKS));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh    <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_rep   <= '0;
    end else begin
      r_press <= w_rise | w_rep_hit;
      if (i_tick) begin
        r_sh    <= w_sh_next;
        r_level <= w_lvl_next;
        if (!REP_EN || w_rise || !w_lvl_next || w_rep_hit)
          r_rep <= '0;
        else if (r_level)
          r_rep <= r_rep + 1'b1;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/btn_inst_frontend.sv
// Operator front end: tick divider, switch capture, per-button debounce,
// pending queue and priority issue of tagged instruction strobes.
module btn_inst_frontend
  import btn_inst_frontend_pkg::*;
#(
  parameter  int NUM_BTN      = 2,
  parameter  int DIV_WIDTH    = 17,
  parameter  int DEB_DEPTH    = 3,
  parameter  int SW_WIDTH     = SEQ_IN_WIDTH,
  parameter  int TAG_WIDTH    = SEQ_TAG_WIDTH,
  parameter  int REPEAT_TICKS = 0,
  parameter  int CNT_WIDTH    = 8,
  localparam int ID_W         = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_BTN-1:0]   btn,
  input  logic [SW_WIDTH-1:0]  sw,
  output logic [SW_WIDTH-1:0]  o_inst,
  output logic                 o_inst_valid,
  output logic [ID_W-1:0]      o_btn_id,
  output logic                 o_tick,
  output logic [CNT_WIDTH-1:0] o_inst_cnt
);

  logic [DIV_WIDTH-1:0] r_div;
  logic                 r_tick;
  logic [SW_WIDTH-1:0]  r_sw_q;
  logic [NUM_BTN-1:0]   r_pend;
  logic [SW_WIDTH-1:0]  r_inst;
  logic                 r_valid;
  logic [ID_W-1:0]      r_id;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic [NUM_BTN-1:0]   w_press;
  logic [NUM_BTN-1:0]   w_onehot;
  logic                 w_hit;
  logic [ID_W-1:0]      w_k;
  logic [TAG_WIDTH-1:0] w_tag;
  logic [SW_WIDTH-1:0]  w_inst;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_deb
    btn_debounce #(
      .DEB_DEPTH    (DEB_DEPTH),
      .REPEAT_TICKS (REPEAT_TICKS)
    ) u_deb (
      .clk     (clk),
      .rst     (rst),
      .i_tick  (r_tick),
      .i_btn   (btn[g]),
      .o_press (w_press[g])
    );
  end

  // Lowest set pending bit wins: isolate it with the two's-complement trick.
  assign w_onehot = r_pend & (~r_pend + 1'b1);
  assign w_hit    = |r_pend;

  always_comb begin
    w_k = '0;
    for (int i = 0; i < NUM_BTN; i++)
      if (w_onehot[i]) w_k = ID_W'(i);
  end

  assign w_tag = TAG_WIDTH'(btn_tag(32'(w_k), TAG_WIDTH));

  always_comb begin
    w_inst = r_sw_q;
    if (w_k != '0)
      w_inst = {w_tag, r_sw_q[SW_WIDTH-TAG_WIDTH-1:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div   <= '0;
      r_tick  <= 1'b0;
      r_sw_q  <= '0;
      r_pend  <= '0;
      r_inst  <= '0;
      r_valid <= 1'b0;
      r_id    <= '0;
      r_cnt   <= '0;
    end else begin
      r_div   <= r_div + 1'b1;
      r_tick  <= &r_div;
      if (r_tick) r_sw_q <= sw;
      r_pend  <= (r_pend & ~w_onehot) | w_press;
      r_valid <= w_hit;
      if (w_hit) begin
        r_inst <= w_inst;
        r_id   <= w_k;
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  assign o_inst       = r_inst;
  assign o_inst_valid = r_valid;
  assign o_btn_id     = r_id;
  assign o_tick       = r_tick;
  assign o_inst_cnt   = r_cnt;

endmodule

// File: tb/tb_btn_inst_frontend.sv
// Directed bench: table of button/switch vectors plus sequences for
// reset/first tick, mid-queue reset, auto-repeat period and count wrap.
module tb_btn_inst_frontend;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Non-repeating instance
  logic       d_rst = 1'b1;
  logic [1:0] d_btn = '0;
  logic [7:0] d_sw  = '0;
  logic [7:0] d_inst;
  logic       d_valid;
  logic [0:0] d_id;
  logic       d_tick;
  logic [7:0] d_cnt;

  // Auto-repeat instance
  logic       r_rst = 1'b1;
  logic [1:0] r_btn = '0;
  logic [7:0] r_sw  = '0;
  logic [7:0] r_inst;
  logic       r_valid;
  logic [0:0] r_id;
  logic       r_tick;
  logic [7:0] r_cnt;

  btn_inst_frontend #(
    .NUM_BTN(2), .DIV_WIDTH(3), .DEB_DEPTH(3), .SW_WIDTH(8),
    .TAG_WIDTH(2), .REPEAT_TICKS(0), .CNT_WIDTH(8)
  ) u_dut (
    .clk(clk), .rst(d_rst), .btn(d_btn), .sw(d_sw),
    .o_inst(d_inst), .o_inst_valid(d_valid), .o_btn_id(d_id),
    .o_tick(d_tick), .o_inst_cnt(d_cnt)
  );

  btn_inst_frontend #(
    .NUM_BTN(2), .DIV_WIDTH(3), .DEB_DEPTH(3), .SW_WIDTH(8),
    .TAG_WIDTH(2), .REPEAT_TICKS(4), .CNT_WIDTH(8)
  ) u_rep (
    .clk(clk), .rst(r_rst), .btn(r_btn), .sw(r_sw),
    .o_inst(r_inst), .o_inst_valid(r_valid), .o_btn_id(r_id),
    .o_tick(r_tick), .o_inst_cnt(r_cnt)
  );

  typedef struct {
    logic [7:0] inst;
    logic       id;
    logic [7:0] cnt;
    int         cyc;
  } stb_t;

  typedef struct {
    logic [1:0] btn;
    logic [7:0] sw;
    int         hold;
    int         n;
    logic [7:0] i0;
    logic       d0;
    logic [7:0] i1;
    logic       d1;
  } vec_t;

  stb_t dq[$];
  stb_t rq[$];
  int   dcyc = 0;
  int   rcyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  // Cycle k is the k-th cycle after the first edge that samples rst low.
  always @(posedge clk) dcyc <= d_rst ? 0 : dcyc + 1;
  always @(posedge clk) rcyc <= r_rst ? 0 : rcyc + 1;

  always @(negedge clk)
    if (d_valid) dq.push_back('{d_inst, d_id[0], d_cnt, dcyc});
  always @(negedge clk)
    if (r_valid) rq.push_back('{r_inst, r_id[0], r_cnt, rcyc});

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic d_reset();
    d_rst = 1'b1;
    d_btn = '0;
    repeat (3) @(negedge clk);
    dq.delete();
    d_rst = 1'b0;
    @(negedge clk);
  endtask

  vec_t vt[8];

  initial begin
    vt[0] = '{2'b01, 8'hA5, 5, 1, 8'hA5, 1'b0, 8'h00, 1'b0};
    vt[1] = '{2'b10, 8'h5A, 3, 1, 8'hDA, 1'b1, 8'h00, 1'b0};
    vt[2] = '{2'b11, 8'h3C, 3, 2, 8'h3C, 1'b0, 8'hFC, 1'b1};
    vt[3] = '{2'b01, 8'h77, 2, 0, 8'h00, 1'b0, 8'h00, 1'b0};
    vt[4] = '{2'b10, 8'h77, 2, 0, 8'h00, 1'b0, 8'h00, 1'b0};
    vt[5] = '{2'b00, 8'h99, 4, 0, 8'h00, 1'b0, 8'h00, 1'b0};
    vt[6] = '{2'b01, 8'hFF, 3, 1, 8'hFF, 1'b0, 8'h00, 1'b0};
    vt[7] = '{2'b10, 8'h00, 3, 1, 8'hC0, 1'b1, 8'h00, 1'b0};

    for (int i = 0; i < 8; i++) begin
      d_sw = vt[i].sw;
      d_reset();
      d_btn = vt[i].btn;
      for (int c = 1; c <= 100; c++) begin
        if (c == vt[i].hold * 8 + 1) d_btn = '0;
        if (c == 25) d_sw = ~vt[i].sw;
        @(negedge clk);
      end
      chk($sformatf("v%0d.count", i), dq.size(), vt[i].n);
      if (dq.size() >= 1) begin
        chk($sformatf("v%0d.inst0", i), dq[0].inst, vt[i].i0);
        chk($sformatf("v%0d.id0", i), dq[0].id, vt[i].d0);
        chk($sformatf("v%0d.cnt0", i), dq[0].cnt, 1);
        chk($sformatf("v%0d.cyc0", i), dq[0].cyc, 27);
      end
      if (dq.size() >= 2) begin
        chk($sformatf("v%0d.inst1", i), dq[1].inst, vt[i].i1);
        chk($sformatf("v%0d.id1", i), dq[1].id, vt[i].d1);
        chk($sformatf("v%0d.cnt1", i), dq[1].cnt, 2);
        chk($sformatf("v%0d.cyc1", i), dq[1].cyc, 28);
      end
      chk($sformatf("v%0d.valid_idle", i), d_valid, 0);
      chk($sformatf("v%0d.cnt_end", i), d_cnt, vt[i].n);
      chk($sformatf("v%0d.inst_hold", i), d_inst,
          (vt[i].n == 2) ? vt[i].i1 : (vt[i].n == 1) ? vt[i].i0 : 8'h00);
      chk($sformatf("v%0d.id_hold", i), d_id,
          (vt[i].n == 2) ? vt[i].d1 : (vt[i].n == 1) ? vt[i].d0 : 1'b0);
    end

    // Reset after activity: outputs clear and first tick lands in cycle 8.
    d_reset();
    chk("rst.inst", d_inst, 0);
    chk("rst.valid", d_valid, 0);
    chk("rst.id", d_id, 0);
    chk("rst.cnt", d_cnt, 0);
    for (int c = 1; c <= 17; c++) begin
      chk($sformatf("rst.tick_c%0d", c), d_tick, (c == 8 || c == 16));
      @(negedge clk);
    end

    // Reset asserted the cycle after pend is set drops the strobe.
    d_sw = 8'h77;
    d_reset();
    d_btn = 2'b01;
    while (dcyc < 26) @(negedge clk);
    d_rst = 1'b1;
    d_btn = '0;
    repeat (5) @(negedge clk);
    chk("midq.inst", d_inst, 0);
    chk("midq.id", d_id, 0);
    chk("midq.cnt", d_cnt, 0);
    chk("midq.tick", d_tick, 0);
    d_rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("midq.no_strobe", dq.size(), 0);
    chk("midq.cnt_after", d_cnt, 0);

    // Auto-repeat: period 32 cycles, count wraps FF -> 00.
    r_sw = 8'h11;
    repeat (2) @(negedge clk);
    rq.delete();
    r_rst = 1'b0;
    @(negedge clk);
    r_btn = 2'b01;
    for (int g = 0; g < 9000 && rq.size() < 256; g++) @(negedge clk);
    chk("rep.count", rq.size(), 256);
    if (rq.size() >= 256) begin
      chk("rep.cyc0", rq[0].cyc, 27);
      chk("rep.cyc1", rq[1].cyc, 59);
      chk("rep.cyc2", rq[2].cyc, 91);
      chk("rep.cnt0", rq[0].cnt, 8'h01);
      chk("rep.cnt254", rq[254].cnt, 8'hFF);
      chk("rep.cnt255", rq[255].cnt, 8'h00);
      chk("rep.inst255", rq[255].inst, 8'h11);
      chk("rep.id255", rq[255].id, 0);
      chk("rep.cyc255", rq[255].cyc, 27 + 255 * 32);
    end
    r_btn = '0;
    r_rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rep.rst_cnt", r_cnt, 0);
    chk("rep.rst_valid", r_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
